micro_sequencer: RTL

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 95 +++++++++
 rtl/micro_sequencer_decode.sv | 16 +
 rtl/micro_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/micro_sequencer_pkg.sv
// Package control: shared definitions for the micro-sequencer slice.
//   - Micro-word geometry (ADDR_BUS_WIDTH, CONTROL_WORD_WIDTH) and the bit
//     position of every field inside a 25-bit micro-word.
//   - Field enums, the sequencer state enum, and the decoded control_word_t.
//   - unpack_word / unpack_ir_op: raw micro-word -> typed fields.
// control_word_t carries bits [24:3] in word order, so {cw, ir_op} == raw word.
package control;

    localparam int ADDR_BUS_WIDTH     = 9;
    localparam int CONTROL_WORD_WIDTH = 25;

    localparam int ALU_OP_HI   = 24;
    localparam int ALU_OP_LO   = 21;
    localparam int ALU_EN_BIT  = 20;
    localparam int MEM_OP_HI   = 19;
    localparam int MEM_OP_LO   = 17;
    localparam int DWS_BIT     = 16;
    localparam int BUS_SEL_BIT = 15;
    localparam int RAX_HI      = 14;
    localparam int RAX_LO      = 13;
    localparam int RBX_HI      = 12;
    localparam int RBX_LO      = 11;
    localparam int RCX_HI      = 10;
    localparam int RCX_LO      = 9;
    localparam int RDX_HI      = 8;
    localparam int RDX_LO      = 7;
    localparam int RESET_BIT   = 6;
    localparam int HALT_BIT    = 5;
    localparam int LOAD_BIT    = 4;
    localparam int NEXT_BIT    = 3;
    localparam int IR_OP_HI    = 2;
    localparam int IR_OP_LO    = 0;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
        ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_NOT = 4'd6, ALU_SHL = 4'd7,
        ALU_SHR = 4'd8
    } alu_op_e;

    typedef enum logic [2:0] {
        NOP = 3'd0, READ = 3'd1, WRITE = 3'd2
    } memory_op_e;

    typedef enum logic [1:0] {
        REG_NOP = 2'd0, REG_LOAD = 2'd1, REG_DRIVE = 2'd2, REG_INC = 2'd3
    } reg_op_e;

    typedef enum logic [2:0] {
        IR_NOP = 3'd0, IR_LOAD_IR = 3'd1, IR_INC_PC = 3'd2, IR_LOAD_PC = 3'd3,
        IR_LOAD_PC_COND = 3'd4
    } instruction_reg_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0, RUN = 2'd1, WAIT_MEM = 2'd2, HALTED = 2'd3
    } seq_state_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_enable;
        memory_op_e memory_op;
        logic       data_word_selector;
        logic       bus_selector;
        reg_op_e    rax_op;
        reg_op_e    rbx_op;
        reg_op_e    rcx_op;
        reg_op_e    rdx_op;
        logic       reset;
        logic       halt;
        logic       control_unit_load;
        logic       next_instr;
    } control_word_t;

    function automatic control_word_t unpack_word(input logic [CONTROL_WORD_WIDTH-1:0] w);
        control_word_t cw;
        cw.alu_op             = alu_op_e'(w[ALU_OP_HI:ALU_OP_LO]);
        cw.alu_enable         = w[ALU_EN_BIT];
        cw.memory_op          = memory_op_e'(w[MEM_OP_HI:MEM_OP_LO]);
        cw.data_word_selector = w[DWS_BIT];
        cw.bus_selector       = w[BUS_SEL_BIT];
        cw.rax_op             = reg_op_e'(w[RAX_HI:RAX_LO]);
        cw.rbx_op             = reg_op_e'(w[RBX_HI:RBX_LO]);
        cw.rcx_op             = reg_op_e'(w[RCX_HI:RCX_LO]);
        cw.rdx_op             = reg_op_e'(w[RDX_HI:RDX_LO]);
        cw.reset              = w[RESET_BIT];
        cw.halt               = w[HALT_BIT];
        cw.control_unit_load  = w[LOAD_BIT];
        cw.next_instr         = w[NEXT_BIT];
        return cw;
    endfunction

    function automatic instruction_reg_op_e unpack_ir_op(input logic [CONTROL_WORD_WIDTH-1:0] w);
        return instruction_reg_op_e'(w[IR_OP_HI:IR_OP_LO]);
    endfunction

endpackage

// File: rtl/micro_sequencer_decode.sv
// micro_word_decode: purely combinational split of a raw micro-ROM word.
//   word_i   : raw 25-bit micro-word
//   cw_o     : typed control word (bits [24:3])
//   ir_op_o  : PC/IR update command (bits [2:0])
module micro_word_decode
    import control::*;
(
    input  logic [CONTROL_WORD_WIDTH-1:0] word_i,
    output control_word_t                 cw_o,
    output instruction_reg_op_e           ir_op_o
);

    assign cw_o    = unpack_word(word_i);
    assign ir_op_o = unpack_ir_op(word_i);

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: steps through a micro-ROM addressed by {ir, step}.
//   clk, rst_n      : clock, async active-low reset
//   ena             : run enable
//   opcode_i        : opcode captured into ir on control_unit_load
//   mem_ready_i     : completes a READ/WRITE micro-step this cycle
//   resume_i        : leaves HALTED
//   ucode_addr_o    : micro-ROM address {ir, step}
//   ucode_word_i    : micro-ROM data for ucode_addr_o (combinational)
//   cw_o, ir_op_o   : decoded control word, all-NOP outside RUN/WAIT_MEM
//   halted_o        : high in HALTED
//   overrun_o       : one-cycle pulse when a routine runs off its last step
module micro_sequencer
    import control::*;
#(
    parameter int OPC_W  = 6,
    parameter int STEP_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [OPC_W-1:0]              opcode_i,
    input  logic                          mem_ready_i,
    input  logic                          resume_i,
    output logic [ADDR_BUS_WIDTH-1:0]     ucode_addr_o,
    input  logic [CONTROL_WORD_WIDTH-1:0] ucode_word_i,
    output control_word_t                 cw_o,
    output instruction_reg_op_e           ir_op_o,
    output logic                          halted_o,
    output logic                          overrun_o
);

    seq_state_e          state, state_nxt;
    logic [OPC_W-1:0]    ir, ir_nxt;
    logic [STEP_W-1:0]   step, step_nxt;
    logic                overrun_q, overrun_nxt;
    control_word_t       dec_cw;
    instruction_reg_op_e dec_ir_op;
    logic                active, mem_access;

    micro_word_decode u_decode (
        .word_i  (ucode_word_i),
        .cw_o    (dec_cw),
        .ir_op_o (dec_ir_op)
    );

    assign active     = (state == RUN) || (state == WAIT_MEM);
    assign mem_access = (dec_cw.memory_op == READ) || (dec_cw.memory_op == WRITE);

    assign ucode_addr_o = {ir, step};
    assign cw_o         = active ? dec_cw : control_word_t'('0);
    assign ir_op_o      = active ? dec_ir_op : IR_NOP;
    assign halted_o     = (state == HALTED);
    assign overrun_o    = overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir        <= '0;
            step      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ir        <= ir_nxt;
            step      <= step_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ir_nxt      = ir;
        step_nxt    = step;
        overrun_nxt = 1'b0;
        case (state)
            IDLE:   if (ena) state_nxt = RUN;
            HALTED: if (resume_i) state_nxt = RUN;
            default: begin
                if (!ena) begin
                    state_nxt = IDLE;
                end else if (mem_access && !mem_ready_i) begin
                    // Pending access: hold address, word stays on cw_o.
                    state_nxt = WAIT_MEM;
                end else begin
                    // Step commits; reset bit beats every other sequencing bit.
                    state_nxt = RUN;
                    if (dec_cw.reset) begin
                        ir_nxt   = '0;
                        step_nxt = '0;
                    end else begin
                        if (dec_cw.next_instr) begin
                            ir_nxt   = '0;
                            step_nxt = '0;
                        end else if (&step) begin
                            // Routine fell off its last step: back to fetch.
                            ir_nxt      = '0;
                            step_nxt    = '0;
                            overrun_nxt = 1'b1;
                        end else begin
                            if (dec_cw.control_unit_load) ir_nxt = opcode_i;
                            step_nxt = step + STEP_W'(1);
                        end
                        if (dec_cw.halt) state_nxt = HALTED;
                    end
                end
            end
        endcase
    end

endmodule
